// File: rtl/btn_evt_pkg.sv
// Shared parameters, id type and round-robin pick helper for the button event arbiter.
package btn_evt_pkg;

  localparam int unsigned N_BTN_DEF           = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned FIFO_DEPTH_DEF      = 4;
  localparam int unsigned BTN_MAX             = 8;
  localparam int unsigned BTN_IDX_W           = 3;

  typedef logic [$clog2(N_BTN_DEF)-1:0] btn_id_t;

  // First set bit of pending at or above ptr, wrapping modulo n (n <= BTN_MAX).
  function automatic logic [BTN_IDX_W-1:0] rr_pick(input logic [BTN_MAX-1:0]   pending,
                                                   input logic [BTN_IDX_W-1:0] ptr,
                                                   input int unsigned          n);
    logic [BTN_IDX_W-1:0] pick;
    logic                 found;
    int unsigned          idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < BTN_MAX; k++) begin
      idx = (32'(ptr) + k) % n;
      if (!found && (k < n) && pending[BTN_IDX_W'(idx)]) begin
        pick  = BTN_IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce counter for one button; pulses press_c on
// the edge where the stable level rises.
module btn_debounce
  import btn_evt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press_c
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             settle_c;

  // Level has differed from stable for DEBOUNCE_CYCLES consecutive samples.
  assign settle_c = (s2 != stable) && (cnt == CNT_LAST);
  assign press_c  = settle_c && s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (settle_c) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounces N_BTN buttons, grants pending presses round-robin into a show-ahead
// event FIFO drained over a valid/ready handshake.
module button_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int unsigned N_BTN           = N_BTN_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic                     Clk,
  input  logic                     ResetN,
  input  logic [N_BTN-1:0]         Bi,
  output logic                     EvtValid,
  output logic [$clog2(N_BTN)-1:0] EvtId,
  input  logic                     EvtReady,
  output logic [N_BTN-1:0]         Pending,
  output logic                     Overflow
);

  localparam int unsigned ID_W  = $clog2(N_BTN);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_BTN - 1);

  logic [N_BTN-1:0] press_c;
  logic [N_BTN-1:0] pending_q;
  logic [N_BTN-1:0] grant_mask_c;
  logic [ID_W-1:0]  grant_id_c;
  logic             grant_c;
  logic             pop_c;
  logic [ID_W-1:0]  rr_ptr;
  logic             overflow_q;
  logic [ID_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (Clk),
      .rst_n  (ResetN),
      .btn    (Bi[i]),
      .press_c(press_c[i])
    );
  end

  // Grant decision uses the registered count only; a same-cycle pop does not free a slot.
  always_comb begin
    grant_mask_c = '0;
    grant_c      = (count < FULL_CNT) && (|pending_q);
    grant_id_c   = ID_W'(rr_pick(BTN_MAX'(pending_q), BTN_IDX_W'(rr_ptr), N_BTN));
    if (grant_c) grant_mask_c[grant_id_c] = 1'b1;
  end

  assign pop_c    = EvtValid && EvtReady;
  assign EvtValid = (count != '0);
  assign EvtId    = fifo_mem[rd_ptr];
  assign Pending  = pending_q;
  assign Overflow = overflow_q;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      // A press on the button being granted this cycle re-arms it instead of merging.
      pending_q <= (pending_q & ~grant_mask_c) | press_c;
      if (|(press_c & pending_q & ~grant_mask_c)) overflow_q <= 1'b1;
      if (grant_c) begin
        fifo_mem[wr_ptr] <= grant_id_c;
        wr_ptr           <= wr_ptr + PTR_W'(1);
        rr_ptr           <= (grant_id_c == LAST_ID) ? '0 : grant_id_c + ID_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      if (grant_c && !pop_c) begin
        count <= count + CNT_W'(1);
      end else if (!grant_c && pop_c) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Front-end controller sharing N_BTN raw push-buttons into one ordered event stream for the processor control unit.
- Each button is synchronized (two register stages) and debounced, and yields exactly one press event per debounced press.
- Pending presses are granted round-robin into a small FIFO, which is drained over a valid/ready handshake.

Parameters:
- N_BTN, 4, number of raw button inputs (2..8).
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized level must differ from the stable level before it is accepted (>=1).
- FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2).

Ports:
- Clk  in  1  system clock.
- ResetN  in  1  reset, asynchronous, active-low.
- Bi  in  N_BTN  raw unregistered button levels, 1 = pressed.
- EvtValid  out  1  FIFO head holds an event.
- EvtId  out  $clog2(N_BTN)  button index at FIFO head; valid only when EvtValid=1.
- EvtReady  in  1  consumer accepts head this cycle.
- Pending  out  N_BTN  per-button press detected, not yet queued.
- Overflow  out  1  sticky; a press was lost.

Behaviour:
- Reset (ResetN=0, asynchronous): sync stages, stable levels, counters, Pending, FIFO pointers/count, RR pointer all clear to 0. EvtValid=0, EvtId=0, Overflow=0 immediately.
- Synchronizer: two flops per bit, s1<=Bi, s2<=s1.
- Debounce, per button:
  - Counter cleared whenever s2==stable.
  - Otherwise counter increments; when counter==DEBOUNCE_CYCLES-1 and s2!=stable, stable<=s2 and counter<=0.
  - Bounces shorter than DEBOUNCE_CYCLES are ignored.
- Press event: stable 0->1 sets Pending[i] on that same edge. Release (1->0) produces no event. Holding a button produces no further events.
- A button held high through reset release produces one event.
- Latency (isolated press, empty FIFO, edge 1 = first edge sampling Bi high): Pending set at edge DEBOUNCE_CYCLES+2; EvtValid high after edge DEBOUNCE_CYCLES+3.
- Arbiter:
  - Each cycle, if FIFO count<FIFO_DEPTH (registered count, no same-cycle pop bypass) and any Pending bit is set, grant the first set bit searching from rr_ptr upward with wrap.
  - On grant: push its index, clear its Pending bit, rr_ptr<=(grant+1) mod N_BTN.
  - One grant per cycle max.
- Overflow: set when a press event occurs on a button whose Pending bit is already 1 and is not being granted that same cycle. The event merges and is lost. Cleared only by reset.
- Press and grant on the same button in the same cycle: Pending stays 1 (new event), Overflow unaffected.
- FIFO: show-ahead; EvtValid=(count!=0); EvtId=head entry.
  - Pop on EvtValid&&EvtReady.
  - Push and pop in the same cycle are legal when 0<count<FIFO_DEPTH; count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - EvtReady while empty is ignored.
- Full FIFO: presses remain in Pending, with no loss until a second press on the same button.

Decomposition:
- Package btn_evt_pkg holds: default N_BTN, FIFO_DEPTH, DEBOUNCE_CYCLES; typedef btn_id_t (logic [$clog2(N_BTN)-1:0]); function rr_pick(pending, ptr).
- Sub-module btn_debounce, one instance per button: synchronizer + debounce counter + press pulse output.
- Arbiter and FIFO live inline in button_event_arbiter.

Test Plan:
- Reset, then Bi[2]=1 held 20 cycles, EvtReady=0, DEBOUNCE_CYCLES=4 -> Pending[2] at edge 6, EvtValid=1/EvtId=2 after edge 7, exactly one event; EvtReady=1 for one cycle -> EvtValid=0 next cycle.
- Bi[0] toggling every 2 cycles for 12 cycles, then held high -> no event during toggling; exactly one event EvtId=0 afterwards.
- All four Bi rise in the same cycle, EvtReady=0, rr_ptr=0 -> pushes on 4 consecutive cycles, drain order 0,1,2,3, final rr_ptr=0.
- FIFO full with 0,1,2,3; press btn1 -> Pending[1]=1, Overflow=0; press btn1 again -> Overflow=1; one pop -> id 1 pushed next cycle, Pending[1]=0.
- rr_ptr=2 with Pending[0] and Pending[3] set together -> 3 queued before 0.
- Three events queued, ResetN=0 mid-cycle -> EvtValid, Pending, Overflow are 0 before the next Clk edge; Bi held high through reset release -> exactly one new event after DEBOUNCE_CYCLES+3 edges.
